// File: rtl/frame_gen_pkg.sv
// ---------------------------------------------------------------------------
// frame_gen_pkg
//   Shared definitions for the frame streaming block:
//     - default frame geometry (pixels per line, lines per frame)
//     - FSM state encoding used by frame_streamer
//     - the four 8-bit gray levels produced from 2-bit pixel codes
//     - a helper that sizes a counter for a given modulus
// ---------------------------------------------------------------------------
package frame_gen_pkg;

    localparam int DEFAULT_FRAME_WIDTH  = 640;
    localparam int DEFAULT_FRAME_HEIGHT = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam logic [7:0] GRAY_BLACK    = 8'h00;
    localparam logic [7:0] GRAY_MID      = 8'h80;
    localparam logic [7:0] GRAY_WHITE    = 8'hFF;
    // The reserved code is shown as mid-gray so a stray code never looks
    // like a saturated pixel.
    localparam logic [7:0] GRAY_RESERVED = 8'h80;

    // Bits needed to count 0..n-1; a one-entry count still gets one bit.
    function automatic int count_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_decode.sv
// ---------------------------------------------------------------------------
// pix_decode
//   Purely combinational translation of a 2-bit pixel code from the pixel
//   memory into an 8-bit grayscale value.
//   Ports:
//     code_i  [1:0]  pixel code (00 black, 01 mid, 11 white, 10 reserved)
//     gray_o  [7:0]  grayscale value
// ---------------------------------------------------------------------------
module pix_decode
    import frame_gen_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [7:0] gray_o
);

    // Table lookup of the gray level; the reserved code falls to default.
    always_comb begin
        gray_o = GRAY_RESERVED;
        case (code_i)
            2'b00:   gray_o = GRAY_BLACK;
            2'b01:   gray_o = GRAY_MID;
            2'b11:   gray_o = GRAY_WHITE;
            default: gray_o = GRAY_RESERVED;
        endcase
    end

endmodule

// File: rtl/frame_streamer.sv
// ---------------------------------------------------------------------------
// frame_streamer
//   Reads a frame from an external pixel memory in raster order and emits it
//   as a valid/ready stream of 8-bit gray beats, one beat per pixel.
//   The memory is addressed directly by the column/row counters and returns
//   the pixel code in the same cycle, so the beat register is the only stage.
//   Parameters:
//     frame_width   pixels per line
//     frame_height  lines per frame
//   Ports:
//     clk         clock, all state on the rising edge
//     rst_n       synchronous active-low reset
//     start       one-cycle request to read a frame (only honoured when idle)
//     continuous  restart automatically after each completed frame
//     width       column address to pixel memory (x)
//     height      row address to pixel memory (y)
//     pix_value   pixel code returned by memory for (width, height)
//     m_data      grayscale beat
//     m_valid     beat (m_data, m_sof, m_eol) is valid
//     m_ready     downstream accepts the beat when m_valid && m_ready
//     m_sof       beat is pixel (0,0)
//     m_eol       beat is the last pixel of a line
//     busy        block is not idle
//     frame_done  one-cycle pulse after the last beat of a frame is accepted
//     frame_cnt   count of completed frames, wrapping
// ---------------------------------------------------------------------------
module frame_streamer
    import frame_gen_pkg::*;
#(
    parameter int frame_width  = DEFAULT_FRAME_WIDTH,
    parameter int frame_height = DEFAULT_FRAME_HEIGHT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    output logic [31:0] width,
    output logic [31:0] height,
    input  logic [1:0]  pix_value,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eol,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int XW = count_bits(frame_width);
    localparam int YW = count_bits(frame_height);

    localparam logic [XW-1:0] X_LAST = XW'(frame_width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(frame_height - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    state_e         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [7:0]     m_data_q, m_data_d;
    logic           m_valid_q, m_valid_d;
    logic           m_sof_q, m_sof_d;
    logic           m_eol_q, m_eol_d;
    logic           frame_done_q, frame_done_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;

    logic [7:0]     gray;
    logic           slot_free;
    logic           beat_accept;
    logic           last_col;
    logic           last_pix;

    pix_decode u_pix_decode (
        .code_i (pix_value),
        .gray_o (gray)
    );

    // The output register can take a new beat when it is empty or its
    // current beat is leaving this cycle.
    assign slot_free   = !m_valid_q || m_ready;
    assign beat_accept = m_valid_q && m_ready;
    assign last_col    = (x_q == X_LAST);
    assign last_pix    = last_col && (y_q == Y_LAST);

    // Next-state and datapath logic. Everything defaults to holding, except
    // m_valid which drops once its beat is taken; loading a new beat below
    // overrides that. In DRAIN the final beat is already in the register and
    // the counters have wrapped to (0,0), ready for a continuous restart.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q && !m_ready;
        m_sof_d      = m_sof_q;
        m_eol_d      = m_eol_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (slot_free) begin
                    m_data_d  = gray;
                    m_sof_d   = (x_q == '0) && (y_q == '0);
                    m_eol_d   = last_col;
                    m_valid_d = 1'b1;
                    if (last_col) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : (y_q + Y_ONE);
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                    if (last_pix) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (beat_accept) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    state_d      = continuous ? ST_STREAM : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            m_data_q     <= 8'h00;
            m_valid_q    <= 1'b0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_sof_q      <= m_sof_d;
            m_eol_q      <= m_eol_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign width      = 32'(x_q);
    assign height     = 32'(y_q);
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_sof      = m_sof_q;
    assign m_eol      = m_eol_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_frame_streamer
//   Directed bench for frame_streamer on a 4x3 frame backed by a small
//   pixel-code table. Inputs are driven and outputs sampled 1 time unit
//   after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_frame_streamer;
    import frame_gen_pkg::*;

    localparam int FW   = 4;
    localparam int FH   = 3;
    localparam int NPIX = FW * FH;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic [31:0] width;
    logic [31:0] height;
    logic [1:0]  pix_value;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eol;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int pixIdx;

    frame_streamer #(
        .frame_width  (FW),
        .frame_height (FH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .width      (width),
        .height     (height),
        .pix_value  (pix_value),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel memory contents in raster order: rows {00,01,11,10},
    // {11,10,00,01}, {01,11,10,00}.
    function automatic logic [1:0] memCode(input int idx);
        case (idx)
            0:  return 2'b00;
            1:  return 2'b01;
            2:  return 2'b11;
            3:  return 2'b10;
            4:  return 2'b11;
            5:  return 2'b10;
            6:  return 2'b00;
            7:  return 2'b01;
            8:  return 2'b01;
            9:  return 2'b11;
            10: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Gray level expected for raster index idx of a frame.
    function automatic logic [7:0] expGray(input int idx);
        case (memCode(idx))
            2'b00:   return 8'h00;
            2'b01:   return 8'h80;
            2'b11:   return 8'hFF;
            default: return 8'h80;
        endcase
    endfunction

    // Combinational memory read; addresses outside the frame read as 00.
    always_comb begin
        pixIdx = NPIX;
        if (width < 32'(FW) && height < 32'(FH)) begin
            pixIdx = int'(height) * FW + int'(width);
        end
        pix_value = memCode(pixIdx);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; m_ready = 1'b0;
        step(); step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", m_data); end
        checks++; if (m_sof !== 1'b0 || m_eol !== 1'b0) begin errors++; $display("[TB] FAIL reset_sof_eol: got %b%b expected 00", m_sof, m_eol); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (width !== 32'd0 || height !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d,%0d expected 0,0", width, height); end
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int k, cyc;
        bit accepting;
        m_ready = 1'b1; continuous = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_first_cycle: got busy=%b valid=%b expected 1,0", busy, m_valid); end
        step();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: got valid=%b expected 1", m_valid); end
        k = 0; cyc = 0;
        while (k < NPIX && cyc < 100) begin
            accepting = (m_valid === 1'b1) && (m_ready === 1'b1);
            if (accepting) begin
                checks++; if (m_data !== expGray(k)) begin errors++; $display("[TB] FAIL basic_data beat %0d: got %h expected %h", k, m_data, expGray(k)); end
                checks++; if (m_sof !== (k == 0)) begin errors++; $display("[TB] FAIL basic_sof beat %0d: got %b expected %b", k, m_sof, (k == 0)); end
                checks++; if (m_eol !== ((k % FW) == FW - 1)) begin errors++; $display("[TB] FAIL basic_eol beat %0d: got %b expected %b", k, m_eol, ((k % FW) == FW - 1)); end
                k++;
            end
            step(); cyc++;
            if (k < NPIX) begin
                checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_done beat %0d: got %b expected 0", k, frame_done); end
            end
        end
        checks++; if (k < NPIX) begin errors++; $display("[TB] FAIL basic_timeout: got %0d beats expected %0d", k, NPIX); end
        checks++; if (cyc !== NPIX) begin errors++; $display("[TB] FAIL basic_throughput: got %0d cycles expected %0d", cyc, NPIX); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b expected 1", frame_done); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_cnt: got %0d expected 1", frame_cnt); end
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", frame_done); end
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got busy=%b valid=%b expected 0,0", busy, m_valid); end
        checks++; if (width !== 32'd0 || height !== 32'd0) begin errors++; $display("[TB] FAIL basic_addr_wrap: got %0d,%0d expected 0,0", width, height); end
    endtask

    task automatic test_backpressure();
        int k, cyc;
        bit accepting, held;
        logic [7:0] heldData;
        logic heldSof, heldEol;
        m_ready = 1'b1; continuous = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        k = 0; cyc = 0; held = 1'b0; heldData = 8'h00; heldSof = 1'b0; heldEol = 1'b0;
        while (k < NPIX && cyc < 200) begin
            m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (held) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== heldData || m_sof !== heldSof || m_eol !== heldEol) begin
                    errors++;
                    $display("[TB] FAIL bp_hold beat %0d: got v=%b d=%h s=%b e=%b expected v=1 d=%h s=%b e=%b", k, m_valid, m_data, m_sof, m_eol, heldData, heldSof, heldEol);
                end
            end
            held = (m_valid === 1'b1) && (m_ready === 1'b0);
            heldData = m_data; heldSof = m_sof; heldEol = m_eol;
            accepting = (m_valid === 1'b1) && (m_ready === 1'b1);
            if (accepting) begin
                checks++; if (m_data !== expGray(k) || m_sof !== (k == 0) || m_eol !== ((k % FW) == FW - 1)) begin
                    errors++; $display("[TB] FAIL bp_beat %0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", k, m_data, m_sof, m_eol, expGray(k), (k == 0), ((k % FW) == FW - 1));
                end
                k++;
            end
            step(); cyc++;
        end
        checks++; if (k < NPIX) begin errors++; $display("[TB] FAIL bp_timeout: got %0d beats expected %0d", k, NPIX); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %b expected 1", frame_done); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL bp_cnt: got %0d expected 2", frame_cnt); end
        m_ready = 1'b1;
        step();
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_extra_beat: got valid=%b busy=%b expected 0,0", m_valid, busy); end
    endtask

    task automatic test_continuous();
        int k, cyc, pulses, lastCyc, idx;
        bit accepting;
        m_ready = 1'b1; continuous = 1'b1;
        start = 1'b1; step(); start = 1'b0; step();
        k = 0; cyc = 0; pulses = 0; lastCyc = 0;
        while (k < 3 * NPIX && cyc < 300) begin
            if (k >= 2 * NPIX) continuous = 1'b0;
            accepting = (m_valid === 1'b1) && (m_ready === 1'b1);
            if (accepting) begin
                idx = k % NPIX;
                checks++; if (m_data !== expGray(idx) || m_sof !== (idx == 0)) begin
                    errors++; $display("[TB] FAIL cont_beat %0d: got d=%h s=%b expected d=%h s=%b", k, m_data, m_sof, expGray(idx), (idx == 0));
                end
                if (idx == 0 && k > 0) begin
                    checks++; if (cyc - lastCyc > 2) begin errors++; $display("[TB] FAIL cont_gap frame %0d: got %0d cycles expected <= 2", k / NPIX, cyc - lastCyc); end
                end
                if (idx == NPIX - 1) lastCyc = cyc;
                k++;
            end
            step(); cyc++;
            if (frame_done === 1'b1) pulses++;
        end
        checks++; if (k < 3 * NPIX) begin errors++; $display("[TB] FAIL cont_timeout: got %0d beats expected %0d", k, 3 * NPIX); end
        checks++; if (pulses !== 3) begin errors++; $display("[TB] FAIL cont_pulses: got %0d expected 3", pulses); end
        checks++; if (frame_cnt !== 16'd5) begin errors++; $display("[TB] FAIL cont_cnt: got %0d expected 5", frame_cnt); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_stop: got busy=%b expected 0", busy); end
    endtask

    task automatic test_start_ignored();
        int k, cyc, pulses;
        bit accepting;
        m_ready = 1'b1; continuous = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        k = 0; cyc = 0; pulses = 0;
        while (k < NPIX && cyc < 100) begin
            start = (cyc == 4);
            accepting = (m_valid === 1'b1) && (m_ready === 1'b1);
            if (accepting) begin
                checks++; if (m_data !== expGray(k) || m_sof !== (k == 0)) begin
                    errors++; $display("[TB] FAIL restart_beat %0d: got d=%h s=%b expected d=%h s=%b", k, m_data, m_sof, expGray(k), (k == 0));
                end
                k++;
            end
            step(); cyc++;
            if (frame_done === 1'b1) pulses++;
        end
        start = 1'b0;
        checks++; if (k < NPIX) begin errors++; $display("[TB] FAIL restart_timeout: got %0d beats expected %0d", k, NPIX); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (frame_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL restart_pulses: got %0d expected 1", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_busy: got %b expected 0", busy); end
        checks++; if (frame_cnt !== 16'd6) begin errors++; $display("[TB] FAIL restart_cnt: got %0d expected 6", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        int k, cyc;
        m_ready = 1'b1; continuous = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        k = 0; cyc = 0;
        while (k < 5 && cyc < 50) begin
            if (m_valid === 1'b1) k++;
            step(); cyc++;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || frame_done !== 1'b0) begin
                errors++; $display("[TB] FAIL midreset_state cycle %0d: got v=%b busy=%b cnt=%0d done=%b expected 0,0,0,0", i, m_valid, busy, frame_cnt, frame_done);
            end
        end
        rst_n = 1'b1; step();
        start = 1'b1; step(); start = 1'b0; step();
        checks++; if (m_valid !== 1'b1 || m_sof !== 1'b1 || m_eol !== 1'b0 || m_data !== expGray(0)) begin
            errors++; $display("[TB] FAIL midreset_first_beat: got v=%b s=%b e=%b d=%h expected v=1 s=1 e=0 d=%h", m_valid, m_sof, m_eol, m_data, expGray(0));
        end
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
    endtask

    task automatic test_drain_stall();
        int k, cyc;
        m_ready = 1'b1; continuous = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        k = 0; cyc = 0;
        while (k < NPIX - 1 && cyc < 100) begin
            if (m_valid === 1'b1) begin
                checks++; if (m_data !== expGray(k)) begin errors++; $display("[TB] FAIL stall_beat %0d: got %h expected %h", k, m_data, expGray(k)); end
                k++;
            end
            step(); cyc++;
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_eol !== 1'b1 || m_data !== expGray(NPIX - 1)) begin
            errors++; $display("[TB] FAIL stall_last_beat: got v=%b e=%b d=%h expected v=1 e=1 d=%h", m_valid, m_eol, m_data, expGray(NPIX - 1));
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (dut.state_q !== ST_DRAIN || busy !== 1'b1 || frame_done !== 1'b0 || m_valid !== 1'b1 || m_data !== expGray(NPIX - 1)) begin
                errors++; $display("[TB] FAIL stall_hold cycle %0d: got st=%0d busy=%b done=%b v=%b d=%h expected st=%0d busy=1 done=0 v=1 d=%h", i, dut.state_q, busy, frame_done, m_valid, m_data, ST_DRAIN, expGray(NPIX - 1));
            end
        end
        m_ready = 1'b1; step();
        checks++; if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL stall_done: got done=%b cnt=%0d expected 1,1", frame_done, frame_cnt); end
        step();
        checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle: got done=%b busy=%b expected 0,0", frame_done, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_continuous();
        test_start_ignored();
        test_reset_midframe();
        test_drain_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected completion within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 The block SHALL take parameter frame_width, default 640, meaning pixels per line.
REQ-002 The block SHALL take parameter frame_height, default 480, meaning lines per frame.
REQ-003 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port start  input  1  one-cycle request to begin frame readout; sampled only in IDLE.
REQ-006 Port continuous  input  1  when 1, the next frame starts automatically after frame_done.
REQ-007 Port width  output  32  column address to pixel memory; equals column counter x.
REQ-008 Port height  output  32  row address to pixel memory; equals row counter y.
REQ-009 Port pix_value  input  2  pixel code returned combinationally for (width, height) in the same cycle.
REQ-010 Port m_data  output  8  grayscale pixel beat.
REQ-011 Port m_valid  output  1  m_data, m_sof and m_eol are valid.
REQ-012 Port m_ready  input  1  downstream accepts the beat when m_valid and m_ready are both 1.
REQ-013 Port m_sof  output  1  beat is pixel (0,0).
REQ-014 Port m_eol  output  1  beat is the last pixel of a line (x = frame_width-1).
REQ-015 Port busy  output  1  1 in any state other than IDLE.
REQ-016 Port frame_done  output  1  one-cycle pulse after the final beat of a frame is accepted.
REQ-017 Port frame_cnt  output  16  completed-frame count; wraps from 0xFFFF to 0.

Function
REQ-018 States: IDLE, STREAM, DRAIN. Transitions:
  - IDLE->STREAM on start=1.
  - STREAM->DRAIN when pixel (frame_width-1, frame_height-1) is loaded.
  - DRAIN->IDLE on acceptance of the last beat if continuous=0.
  - DRAIN->STREAM on acceptance of the last beat if continuous=1.
REQ-019 The output slot SHALL be free when m_valid=0 or m_ready=1. In STREAM with the slot free, the block SHALL do all of the following in one cycle:
  - load m_data from pix_value;
  - set m_sof=(x==0 && y==0);
  - set m_eol=(x==frame_width-1);
  - set m_valid=1;
  - advance the counters.
REQ-020 Counter advance: x increments. At x=frame_width-1, x SHALL go to 0 and y SHALL increment. At the final pixel, x and y SHALL go to 0.
REQ-021 Code mapping: 2'b00->8'h00, 2'b01->8'h80, 2'b11->8'hFF, 2'b10 (reserved)->8'h80.
REQ-022 When the slot is not free, m_data, m_sof, m_eol, m_valid, x and y SHALL hold unchanged; no pixel SHALL be skipped or repeated.
REQ-023 m_valid SHALL clear when a beat is accepted and no new beat is loaded that cycle.
REQ-024 Latency: the first beat SHALL have m_valid=1 exactly 2 cycles after start is sampled, i.e. one cycle in STREAM then registered. With m_ready held at 1, throughput SHALL be one beat per cycle, and a frame SHALL complete in frame_width*frame_height beats.
REQ-025 frame_done SHALL pulse in the cycle after the last beat is accepted. frame_cnt SHALL increment in that same cycle.
REQ-026 In continuous mode, the first beat of the next frame SHALL follow the final beat with no more than one idle cycle.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 width and height SHALL carry x and y zero-extended to 32 bits and SHALL never exceed frame_width-1 and frame_height-1 respectively.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force the following, with any partial frame abandoned:
  - state=IDLE;
  - x=0, y=0;
  - m_valid=0, m_data=0, m_sof=0, m_eol=0;
  - frame_done=0;
  - frame_cnt=0.
REQ-030 The first beat after reset release and start SHALL be pixel (0,0) with m_sof=1.

Structure
REQ-031 A shared package frame_gen_pkg SHALL hold:
  - the default frame dimensions;
  - the state encoding;
  - the four 8-bit gray constants.
REQ-032 The code-to-gray mapping SHALL be one combinational sub-module, pix_decode (2-bit in, 8-bit out).
REQ-033 The block SHALL connect directly to the existing pixel memory through width, height and pix_value, with no extra pipeline stage on the address path.

Verification
REQ-034 Use frame_width=4, frame_height=3, memory row 0 = {00,01,11,10}, m_ready=1, pulse start. Required: beats 00,80,FF,80. m_sof=1 on beat 0 only. m_eol=1 on beats 3, 7 and 11. frame_done one cycle after beat 11. frame_cnt=1.
REQ-035 Same frame with m_ready toggled 1,0,0,1 repeating. Required: exactly 12 accepted beats in raster order, with m_data stable while m_valid=1 and m_ready=0.
REQ-036 continuous=1 for 3 frames. Required: three frame_done pulses, frame_cnt=3, and at most one idle cycle between the final beat of one frame and the m_sof beat of the next.
REQ-037 Pulse start again during STREAM. Required: no restart, counters unaffected, and a single frame_done.
REQ-038 Assert rst_n=0 at beat 5, then release and pulse start. Required: while in reset, m_valid=0, busy=0 and frame_cnt=0. After start, the first beat is (0,0) with m_sof=1.
REQ-039 Hold m_ready=0 on the final beat for 10 cycles. Required: state stays DRAIN, busy=1, and frame_done fires only after acceptance.
